mux2to1: RTL and testbench

//   Registered 2:1 word selector. Forwards in1 when s=0 and in2 when s=1.

---
 rtl/mux_pkg.sv | 8 +
 rtl/mux_reg.sv | 20 ++
 rtl/mux2to1.sv | 35 +++
 tb/tb_mux2to1.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared datapath word definitions for the word-selector slice.
package mux_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

endpackage : mux_pkg

// File: rtl/mux_reg.sv
// WIDTH-bit register with synchronous active-high reset to RESET_VAL.
module mux_reg #(
  parameter int               WIDTH     = mux_pkg::DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule : mux_reg

// File: rtl/mux2to1.sv
// Registered 2:1 word selector: mux_out follows (s ? in2 : in1) one clk later.
module mux2to1
  import mux_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] mux_out
);

  if (WIDTH < 1) begin : g_bad_width
    $error("mux2to1: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] sel_d;

  // Conditional operator keeps an unknown select visible as X in simulation.
  assign sel_d = s ? in2 : in1;

  mux_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_mux_reg (
    .clk   (clk),
    .reset (reset),
    .d     (sel_d),
    .q     (mux_out)
  );

endmodule : mux2to1

// File: tb/tb_mux2to1.sv
// Self-checking bench for mux2to1: directed cases plus randomized traffic vs a reference model.
module tb_mux2to1;
  import mux_pkg::*;

  localparam word_t RST_WORD = 16'h0000;

  logic  clk;
  logic  reset;
  logic  s;
  word_t in1;
  word_t in2;
  word_t mux_out;

  int n_checks;
  int n_errors;

  mux2to1 #(
    .WIDTH     (DATA_W),
    .RESET_VAL (RST_WORD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s       (s),
    .in1     (in1),
    .in2     (in2),
    .mux_out (mux_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_word(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: reset wins; otherwise the source picked by s from the pair {in1, in2}.
  function automatic word_t ref_model(input logic rst, input logic sel, input word_t a, input word_t b);
    word_t src[2];
    if (rst) return RST_WORD;
    src[0] = a;
    src[1] = b;
    return src[int'(sel)];
  endfunction

  // Inputs change on the falling edge; the value captured at the rising edge is checked at the next falling edge.
  task automatic tick(input string tag);
    word_t exp;
    @(posedge clk);
    exp = ref_model(reset, s, in1, in2);
    @(negedge clk);
    check_word(tag, mux_out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    s     = 1'($urandom);
    in1   = word_t'($urandom);
    in2   = word_t'($urandom);
    @(negedge clk);

    // 1. reset with arbitrary inputs
    for (int i = 0; i < 2; i++) begin
      s   = 1'($urandom);
      in1 = word_t'($urandom);
      in2 = word_t'($urandom);
      tick("reset");
      check_word("reset_const", mux_out, 16'h0000);
    end
    reset = 1'b0;

    // 2. select in1
    s = 1'b0; in1 = 16'hA5A5; in2 = 16'hFFFF;
    tick("sel_in1_a"); tick("sel_in1_a2");
    check_word("sel_in1_a_const", mux_out, 16'hA5A5);
    in1 = 16'h5A5A;
    tick("sel_in1_b"); tick("sel_in1_b2");
    check_word("sel_in1_b_const", mux_out, 16'h5A5A);

    // 3. select in2
    s = 1'b1; in1 = 16'hFFFF; in2 = 16'hA5A5;
    tick("sel_in2_a"); tick("sel_in2_a2");
    check_word("sel_in2_a_const", mux_out, 16'hA5A5);
    in2 = 16'h5A5A;
    tick("sel_in2_b"); tick("sel_in2_b2");
    check_word("sel_in2_b_const", mux_out, 16'h5A5A);

    // 4. unselected input toggling
    s = 1'b1; in2 = 16'h3C3C;
    for (int i = 0; i < 8; i++) begin
      in1 = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
      tick("unsel_toggle");
      if (i > 0) check_word("unsel_hold", mux_out, 16'h3C3C);
    end

    // 5. latency of a select change
    s = 1'b0; in1 = 16'h1234; in2 = 16'hBEEF;
    tick("lat_pre"); tick("lat_pre2");
    s = 1'b1;
    #1 check_word("lat_before_edge", mux_out, 16'h1234);
    tick("lat_after_edge");
    check_word("lat_after_const", mux_out, 16'hBEEF);

    // 6. mid-stream reset
    s = 1'b1; in2 = 16'hBEEF;
    tick("mid_pre");
    reset = 1'b1;
    tick("mid_reset");
    check_word("mid_reset_const", mux_out, 16'h0000);
    reset = 1'b0;
    tick("mid_release");
    check_word("mid_release_const", mux_out, 16'hBEEF);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 15) == 0);
      s     = 1'($urandom);
      in1   = word_t'($urandom);
      in2   = word_t'($urandom);
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mux2to1
